// File: rtl/signal_ramper_pkg.sv
// Shared types and constants for the multi-channel envelope ramper.
// Build option: SIGNAL_RAMPER_STATE_DEBUG_EN exposes per-channel state encodings.
package signal_ramper_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_UP   = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_NORMAL    = 3'd2,
        ST_REQ_DOWN  = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_DONE      = 3'd5
    } ramp_state_e;

    localparam int L_WIDTH = 3;
    localparam int K_WIDTH = 7;

    function automatic int full_scale(input int amp_width);
        return (32'sd1 <<< amp_width) - 32'sd1;
    endfunction

endpackage

// File: rtl/ramp_channel_fsm.sv
// One envelope channel: ramp-up / hold / ramp-down / done sequencing and registered output.
// Build option: SIGNAL_RAMPER_STATE_DEBUG_EN adds the state_dbg port.
module ramp_channel_fsm
    import signal_ramper_pkg::*;
#(
    parameter int AMP_WIDTH = 13,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic                 wrap,
    input  logic [AMP_WIDTH-1:0] phase,
    input  logic                 enable,
    input  logic                 start_down,
    input  logic                 restart,
    input  logic [L_WIDTH-1:0]   periods_log2,
    output logic [OUT_WIDTH-1:0] ramp,
    output logic                 done
`ifdef SIGNAL_RAMPER_STATE_DEBUG_EN
    ,
    output logic [2:0]           state_dbg
`endif
);

    localparam logic [AMP_WIDTH-1:0] FS = AMP_WIDTH'(full_scale(AMP_WIDTH));

    ramp_state_e          state_r;
    logic [K_WIDTH-1:0]   k_r;
    logic [L_WIDTH-1:0]   l_ch_r;
    logic                 req_r;

    // {k,p} >> L never exceeds full scale because k < 2^L.
    function automatic logic [AMP_WIDTH-1:0] ramp_env(input logic [K_WIDTH-1:0] k,
                                                      input logic [AMP_WIDTH-1:0] p,
                                                      input logic [L_WIDTH-1:0] l);
        logic [K_WIDTH+AMP_WIDTH-1:0] acc;
        acc = {k, p} >> l;
        return acc[AMP_WIDTH-1:0];
    endfunction

    function automatic logic last_period(input logic [K_WIDTH-1:0] k, input logic [L_WIDTH-1:0] l);
        return k == ((K_WIDTH'(1) << l) - K_WIDTH'(1));
    endfunction

    function automatic logic [OUT_WIDTH-1:0] shape(input logic en, input logic [AMP_WIDTH-1:0] env);
        return en ? {{(OUT_WIDTH-AMP_WIDTH){1'b0}}, env} : {{(OUT_WIDTH-AMP_WIDTH){1'b0}}, FS};
    endfunction

    // Envelope sequencer with registered envelope and done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT_UP;
            k_r     <= K_WIDTH'(0);
            l_ch_r  <= L_WIDTH'(0);
            req_r   <= 1'b0;
            ramp    <= OUT_WIDTH'(0);
            done    <= 1'b0;
        end else begin
            if (start_down && (state_r inside {ST_WAIT_UP, ST_RAMP_UP, ST_NORMAL})) begin
                req_r <= 1'b1;
            end
            if (sample_valid) begin
                done <= 1'b0;
                case (state_r)
                    ST_WAIT_UP: begin
                        if (wrap) begin
                            state_r <= ST_RAMP_UP;
                            k_r     <= K_WIDTH'(0);
                            l_ch_r  <= periods_log2;
                            ramp    <= shape(enable, ramp_env(K_WIDTH'(0), phase, periods_log2));
                        end else begin
                            ramp    <= shape(enable, AMP_WIDTH'(0));
                        end
                    end
                    ST_RAMP_UP: begin
                        if (wrap && last_period(k_r, l_ch_r)) begin
                            state_r <= (req_r || start_down) ? ST_REQ_DOWN : ST_NORMAL;
                            req_r   <= 1'b0;
                            ramp    <= shape(enable, FS);
                        end else if (wrap) begin
                            k_r     <= k_r + K_WIDTH'(1);
                            ramp    <= shape(enable, ramp_env(k_r + K_WIDTH'(1), phase, l_ch_r));
                        end else begin
                            ramp    <= shape(enable, ramp_env(k_r, phase, l_ch_r));
                        end
                    end
                    ST_NORMAL: begin
                        if (start_down || req_r) begin
                            state_r <= ST_REQ_DOWN;
                            req_r   <= 1'b0;
                        end else begin
                            state_r <= ST_NORMAL;
                        end
                        ramp <= shape(enable, FS);
                    end
                    ST_REQ_DOWN: begin
                        if (wrap) begin
                            state_r <= ST_RAMP_DOWN;
                            k_r     <= K_WIDTH'(0);
                            l_ch_r  <= periods_log2;
                            ramp    <= shape(enable, FS - ramp_env(K_WIDTH'(0), phase, periods_log2));
                        end else begin
                            ramp    <= shape(enable, FS);
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (wrap && last_period(k_r, l_ch_r)) begin
                            state_r <= ST_DONE;
                            ramp    <= shape(enable, AMP_WIDTH'(0));
                            done    <= 1'b1;
                        end else if (wrap) begin
                            k_r     <= k_r + K_WIDTH'(1);
                            ramp    <= shape(enable, FS - ramp_env(k_r + K_WIDTH'(1), phase, l_ch_r));
                        end else begin
                            ramp    <= shape(enable, FS - ramp_env(k_r, phase, l_ch_r));
                        end
                    end
                    ST_DONE: begin
                        if (restart) begin
                            state_r <= ST_WAIT_UP;
                        end else begin
                            done    <= 1'b1;
                        end
                        ramp <= shape(enable, AMP_WIDTH'(0));
                    end
                    default: begin
                        state_r <= ST_WAIT_UP;
                        ramp    <= OUT_WIDTH'(0);
                    end
                endcase
            end
        end
    end

`ifdef SIGNAL_RAMPER_STATE_DEBUG_EN
    assign state_dbg = state_r;
`endif

endmodule

// File: rtl/signal_ramper_multi.sv
// Multi-channel envelope ramper: shared phase register and wrap detector feeding per-channel FSMs.
// Build option: SIGNAL_RAMPER_STATE_DEBUG_EN adds the rampState output.
module signal_ramper_multi
    import signal_ramper_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int PHASE_WIDTH = 48,
    parameter int AMP_WIDTH   = 13,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [PHASE_WIDTH-1:0]        s_axis_tdata_phase,
    input  logic                          s_axis_tvalid_phase,
    input  logic [CHANNELS-1:0]           enableRamping,
    input  logic [CHANNELS-1:0]           startRampDown,
    input  logic [CHANNELS-1:0]           rampRestart,
    input  logic [L_WIDTH-1:0]            rampPeriodsLog2,
    output logic [CHANNELS*OUT_WIDTH-1:0] ramp,
    output logic [CHANNELS-1:0]           rampDone
`ifdef SIGNAL_RAMPER_STATE_DEBUG_EN
    ,
    output logic [3*CHANNELS-1:0]         rampState
`endif
);

    logic [1:0]           rst_sync_r;
    logic                 rst_n;
    logic [AMP_WIDTH-1:0] p_new_s;
    logic [AMP_WIDTH-1:0] p_r;
    logic                 have_prev_r;
    logic                 wrap_r;
    logic                 valid_r;
    logic                 unused_phase_lsbs;

    assign p_new_s           = s_axis_tdata_phase[PHASE_WIDTH-1 -: AMP_WIDTH];
    assign unused_phase_lsbs = ^s_axis_tdata_phase[PHASE_WIDTH-AMP_WIDTH-1:0];

    // Reset asserts immediately, releases two clocks after aresetn rises.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_r[1];

    // Phase register and wrap detection; the first sample after reset has no predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r         <= AMP_WIDTH'(0);
            have_prev_r <= 1'b0;
            wrap_r      <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            valid_r <= s_axis_tvalid_phase;
            if (s_axis_tvalid_phase) begin
                p_r         <= p_new_s;
                have_prev_r <= 1'b1;
                wrap_r      <= have_prev_r && (p_new_s < p_r);
            end else begin
                wrap_r      <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ramp_channel_fsm #(
            .AMP_WIDTH(AMP_WIDTH),
            .OUT_WIDTH(OUT_WIDTH)
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .sample_valid (valid_r),
            .wrap         (wrap_r),
            .phase        (p_r),
            .enable       (enableRamping[c]),
            .start_down   (startRampDown[c]),
            .restart      (rampRestart[c]),
            .periods_log2 (rampPeriodsLog2),
            .ramp         (ramp[c*OUT_WIDTH +: OUT_WIDTH]),
            .done         (rampDone[c])
`ifdef SIGNAL_RAMPER_STATE_DEBUG_EN
            ,
            .state_dbg    (rampState[3*c +: 3])
`endif
        );
    end

endmodule

// File: doc/signal_ramper_multi.md
# signal_ramper_multi

Per-channel amplitude envelope generator for the DAC path: derives period boundaries from the shared DDS phase stream and produces, per channel, a linear ramp-up over 2^L signal periods, a full-scale hold, a period-aligned ramp-down on request, and a zero hold until re-armed. It sits between the phase generator and the DAC amplitude multipliers, replacing the single-channel, single-period ramper with a re-armable, multi-channel, parametrised version.

## Interface
- CHANNELS, 2, number of independent envelope channels
- PHASE_WIDTH, 48, width of the incoming phase word
- AMP_WIDTH, 13, envelope resolution; full scale FS = 2^AMP_WIDTH-1 (8191)
- OUT_WIDTH, 16, output word width per channel, FS zero-extended (OUT_WIDTH > AMP_WIDTH)
- clk  in  1  system clock; one clock, all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_tdata_phase  in  PHASE_WIDTH  phase accumulator value; top AMP_WIDTH bits used as phase p
- s_axis_tvalid_phase  in  1  phase sample valid; all state advances only on valid samples
- enableRamping  in  CHANNELS  per channel: 1 = envelope applied, 0 = output forced to FS
- startRampDown  in  CHANNELS  per channel level/pulse requesting ramp-down
- rampRestart  in  CHANNELS  per channel, re-arms a channel in DONE
- rampPeriodsLog2  in  3  L: ramp spans 2^L periods (1..128)
- ramp  out  CHANNELS*OUT_WIDTH  envelopes, channel 0 in LSBs
- rampDone  out  CHANNELS  1 while channel is in DONE

## Operation
- Wrap detect (shared): p registered on each valid sample; wrap = valid & (p_new < p_reg). First valid after reset never wraps.
- Per-channel states: WAIT_UP, RAMP_UP, NORMAL, REQ_DOWN, RAMP_DOWN, DONE. Reset state WAIT_UP.
- WAIT_UP -> RAMP_UP on wrap; latch L into L_ch, clear period counter k.
- RAMP_UP: env = ({k, p} >> L_ch); k increments on wrap; on wrap with k = 2^L_ch-1 -> NORMAL, or -> REQ_DOWN if a down request was latched during RAMP_UP.
- NORMAL: env = FS; startRampDown=1 -> REQ_DOWN.
- REQ_DOWN: env = FS; on wrap -> RAMP_DOWN, latch L, clear k.
- RAMP_DOWN: env = FS - ({k, p} >> L_ch); on wrap with k = 2^L_ch-1 -> DONE.
- DONE: env = 0; rampDone=1; rampRestart=1 -> WAIT_UP. startRampDown ignored.
- startRampDown in WAIT_UP/RAMP_UP is latched (sticky) and cleared on entering REQ_DOWN or by reset.
- rampRestart outside DONE ignored.
- enableRamping=0: output FS but FSM keeps running; re-enabling shows current envelope, no glitch suppression.
- L changes mid-ramp take effect only at next latch point.
- Arithmetic: {k,p} is (7+AMP_WIDTH) bits unsigned, shift result truncated to AMP_WIDTH; no overflow since k < 2^L.

## Timing
- Reset: ramp = 0 for all channels, rampDone = 0, k = 0, latched requests cleared; asserted asynchronously, released synchronously.
- Latency: valid phase sample to ramp update = 2 clk (phase register, output register). rampDone registered, aligned with ramp.
- State transitions occur on the same edge as the wrap-qualified sample; the first post-transition envelope value appears with that sample's output.
- No valid samples: outputs and states hold.
- Reset mid-ramp: output drops to 0 immediately; restarts in WAIT_UP.

## Configuration
- SIGNAL_RAMPER_STATE_DEBUG_EN defined: extra output rampState [3*CHANNELS-1:0], registered encoded state per channel (WAIT_UP=0 ... DONE=5), reset 0.
- Undefined: port and its register absent; functional behaviour identical.

## Structure
- Package signal_ramper_pkg: state enum (3-bit encodings above), FS constant function of AMP_WIDTH, L width constant.
- Sub-module ramp_channel_fsm: one per channel via generate; top holds shared phase register and wrap detector.

## Test plan
- L=0, phase step 1024 (top bits) per valid, 8 samples/period: after first wrap ramp ch0 = 0,1024,...,7168, then 8191 constant; rampDone=0.
- L=1: up values 0,512,...,3584,4096,...,7680 across two periods, then 8191; startRampDown pulse in NORMAL -> FS until next wrap, then 8191-0, 8191-512, ... -> 0 after two periods, rampDone=1.
- startRampDown asserted during RAMP_UP (L=0): no NORMAL period; REQ_DOWN then ramp-down starts at the wrap after ramp-up completes.
- ch0 enableRamping=0, ch1=1 with independent down requests: ch0 ramp = 8191 always; ch1 follows envelope; rampDone per channel independent.
- DONE + rampRestart pulse: WAIT_UP, ramp=0 until next wrap, then ramp-up repeats; rampRestart in NORMAL has no effect.
- aresetn low mid RAMP_DOWN for 1 cycle: ramp=0 same cycle, state WAIT_UP, sticky request cleared; tvalid held low -> outputs hold.
